// File: rtl/conv_pe_array_if.sv
// Weight-load, column-input and result-output signals of the convolution PE array.
// Pure wiring bundle: no storage, so it adds no latency.
// in_ready throttles the column stream; out_valid cannot be back-pressured.
interface conv_pe_array_if #(
    parameter int K        = 3,
    parameter int OUT_ROWS = 4,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8
);
    localparam int ROWS_IN = OUT_ROWS + K - 1;

    logic                         w_valid;
    logic [WEIGHT_W-1:0]          w_data;
    logic                         w_loaded;
    logic                         relu_en;
    logic                         in_valid;
    logic                         in_ready;
    logic                         in_first;
    logic [ROWS_IN*DATA_W-1:0]    in_data;
    logic                         out_valid;
    logic [OUT_ROWS*DATA_W-1:0]   out_data;

    // Feeder / writer side
    modport master (
        output w_valid, w_data, relu_en, in_valid, in_first, in_data,
        input  w_loaded, in_ready, out_valid, out_data
    );

    // PE array side
    modport slave (
        input  w_valid, w_data, relu_en, in_valid, in_first, in_data,
        output w_loaded, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/conv_pe_array.sv
// KxK convolution PE array: sliding column window, serial kernel load, requantised outputs.
// Latency 3 cycles from column accept to out_valid; one column per cycle throughput.
// in_ready low unless a kernel is loaded and no weight beat is present; outputs never stall.
module conv_pe_array #(
    parameter int K        = 3,
    parameter int OUT_ROWS = 4,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int SHIFT    = 0
) (
    input  logic           clk,
    input  logic           rst,
    conv_pe_array_if.slave bus
);
    localparam int ROWS_IN = OUT_ROWS + K - 1;
    localparam int NW      = K * K;
    localparam int PROD_W  = DATA_W + WEIGHT_W;
    localparam int ACC_W   = DATA_W + WEIGHT_W + $clog2(NW);
    localparam int CNT_W   = $clog2(NW + 1);
    localparam int FILL_W  = $clog2(K + 1);

    localparam logic [CNT_W-1:0]        LAST_BEAT = CNT_W'(NW - 1);
    localparam logic [FILL_W-1:0]       FILL_FULL = FILL_W'(K);
    localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN   = ACC_W'(-(1 << (DATA_W - 1)));

    typedef enum logic [1:0] {ST_EMPTY, ST_LOAD, ST_RUN} state_t;

    state_t                      state, state_nxt;
    logic [CNT_W-1:0]            cnt, cnt_nxt;
    logic [CNT_W-1:0]            w_idx;
    logic                        w_we;
    logic                        flush;
    logic                        in_ready_int;
    logic                        accept;
    logic                        launch;
    logic [FILL_W-1:0]           fill, fill_nxt;
    logic signed [WEIGHT_W-1:0]  wgt [NW];
    logic signed [DATA_W-1:0]    win [ROWS_IN][K];
    logic                        v1, v2, out_valid_q;
    logic signed [ACC_W-1:0]     acc_c [OUT_ROWS];
    logic signed [ACC_W-1:0]     acc_q [OUT_ROWS];
    logic [OUT_ROWS*DATA_W-1:0]  out_c, out_q;

    // Full-precision product, sign-extended to accumulator width
    function automatic logic signed [ACC_W-1:0] mul_ext(
        input logic signed [DATA_W-1:0]   x,
        input logic signed [WEIGHT_W-1:0] w
    );
        logic signed [PROD_W-1:0] p;
        p = PROD_W'(x) * PROD_W'(w);
        return ACC_W'(p);
    endfunction

    // Floor shift, optional ReLU, then saturate into the output width
    function automatic logic [DATA_W-1:0] requant(
        input logic signed [ACC_W-1:0] a,
        input logic                    relu
    );
        logic signed [ACC_W-1:0] y;
        y = a >>> SHIFT;
        if (relu && y[ACC_W-1]) y = '0;
        if (y > SAT_MAX)      y = SAT_MAX;
        else if (y < SAT_MIN) y = SAT_MIN;
        return y[DATA_W-1:0];
    endfunction

    // Load FSM state and weight beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Load FSM next state; a weight beat in RUN restarts the load and flushes work in flight
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        w_we      = 1'b0;
        w_idx     = cnt;
        flush     = 1'b0;
        case (state)
            ST_EMPTY, ST_RUN: begin
                if (bus.w_valid) begin
                    w_we  = 1'b1;
                    w_idx = '0;
                    flush = (state == ST_RUN);
                    if (NW == 1) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_LOAD;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            ST_LOAD: begin
                if (bus.w_valid) begin
                    w_we = 1'b1;
                    if (cnt == LAST_BEAT) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    assign in_ready_int = (state == ST_RUN) & ~bus.w_valid;
    assign accept       = bus.in_valid & in_ready_int;
    assign bus.in_ready = in_ready_int;
    assign bus.w_loaded = (state == ST_RUN);

    // Window fill tracking: in_first restarts the strip, count saturates at K
    always_comb begin
        if (bus.in_first)           fill_nxt = FILL_W'(1);
        else if (fill == FILL_FULL) fill_nxt = fill;
        else                        fill_nxt = fill + 1'b1;
    end

    assign launch = accept & (fill_nxt == FILL_FULL);

    // Kernel registers, written only by load beats
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NW; i++) wgt[i] <= '0;
        end else if (w_we) begin
            wgt[w_idx] <= bus.w_data;
        end
    end

    // Fill counter; cleared on reload so a fresh window is required
    always_ff @(posedge clk) begin
        if (rst)         fill <= '0;
        else if (flush)  fill <= '0;
        else if (accept) fill <= fill_nxt;
    end

    // Sliding window: column 0 is oldest, new column enters at K-1
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS_IN; r++)
                for (int c = 0; c < K; c++) win[r][c] <= '0;
        end else if (accept) begin
            for (int r = 0; r < ROWS_IN; r++) begin
                for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
                win[r][K-1] <= bus.in_data[r*DATA_W +: DATA_W];
            end
        end
    end

    // Multiply-accumulate over the KxK window for every output row
    always_comb begin
        for (int j = 0; j < OUT_ROWS; j++) begin
            acc_c[j] = '0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    acc_c[j] = acc_c[j] + mul_ext(win[j+r][c], wgt[r*K+c]);
        end
    end

    // Requantise accumulators into the packed output word
    always_comb begin
        out_c = '0;
        for (int j = 0; j < OUT_ROWS; j++)
            out_c[j*DATA_W +: DATA_W] = requant(acc_q[j], bus.relu_en);
    end

    // Pipeline valids; a reload drops every result still in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            v1          <= launch & ~flush;
            v2          <= v1 & ~flush;
            out_valid_q <= v2 & ~flush;
        end
    end

    // Accumulator and output data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < OUT_ROWS; j++) acc_q[j] <= '0;
            out_q <= '0;
        end else begin
            if (v1) acc_q <= acc_c;
            if (v2) out_q <= out_c;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q;
endmodule

// File: tb/tb_conv_pe_array.sv
module tb_conv_pe_array;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_valid = 1'b0;
    logic [7:0]  w_data = '0;
    logic        relu_en = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_first = 1'b0;
    logic [47:0] in_data = '0;

    always #5 clk = ~clk;

    conv_pe_array_if #(.K(3), .OUT_ROWS(4), .DATA_W(8), .WEIGHT_W(8)) if0 ();
    conv_pe_array_if #(.K(3), .OUT_ROWS(4), .DATA_W(8), .WEIGHT_W(8)) if2 ();

    assign if0.w_valid = w_valid;   assign if2.w_valid = w_valid;
    assign if0.w_data = w_data;     assign if2.w_data = w_data;
    assign if0.relu_en = relu_en;   assign if2.relu_en = relu_en;
    assign if0.in_valid = in_valid; assign if2.in_valid = in_valid;
    assign if0.in_first = in_first; assign if2.in_first = in_first;
    assign if0.in_data = in_data;   assign if2.in_data = in_data;

    conv_pe_array #(.K(3), .OUT_ROWS(4), .DATA_W(8), .WEIGHT_W(8), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    conv_pe_array #(.K(3), .OUT_ROWS(4), .DATA_W(8), .WEIGHT_W(8), .SHIFT(2)) dut2 (
        .clk(clk), .rst(rst), .bus(if2.slave));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] d0;
        logic [31:0] d2;
    } exp_t;
    exp_t q[$];

    // reference model state: 0 EMPTY, 1 LOAD, 2 RUN
    int m_state, m_cnt, m_fill;
    int mw[9];
    int mwin[6][3];
    int kbuf[9];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_fill = 0;
        for (int i = 0; i < 9; i++) mw[i] = 0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 3; c++) mwin[r][c] = 0;
    endtask

    function automatic logic [31:0] expect_col(input int sh, input bit relu);
        logic [31:0] res;
        int acc, y;
        res = '0;
        for (int j = 0; j < 4; j++) begin
            acc = 0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) acc += mw[r*3+c] * mwin[j+r][c];
            y = acc >>> sh;
            if (relu && y < 0) y = 0;
            if (y > 127) y = 127;
            if (y < -128) y = -128;
            res[j*8 +: 8] = y[7:0];
        end
        return res;
    endfunction

    function automatic logic [47:0] all_rows(input int v);
        logic [7:0] b;
        b = v[7:0];
        return {6{b}};
    endfunction

    function automatic logic [47:0] rnd48();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[47:0];
    endfunction

    // Output monitor: compares against the scoreboard head due this cycle
    always @(negedge clk) begin
        bit ev;
        while (q.size() > 0 && q[0].due < cyc) begin
            chk("stale_due", q[0].due, cyc);
            void'(q.pop_front());
        end
        ev = (q.size() > 0) && (q[0].due == cyc);
        if (if0.out_valid === 1'b1 || ev) chk("out_valid_s0", if0.out_valid, ev);
        if (if2.out_valid === 1'b1 || ev) chk("out_valid_s2", if2.out_valid, ev);
        if (ev) begin
            if (if0.out_valid) chk("out_data_s0", if0.out_data, q[0].d0);
            if (if2.out_valid) chk("out_data_s2", if2.out_data, q[0].d2);
            void'(q.pop_front());
        end
    end

    // One clock of stimulus: drive, check handshake, advance model
    task automatic cycle(input logic wv, input logic [7:0] wd, input logic iv,
                         input logic ifst, input logic [47:0] idat);
        bit exp_rdy;
        exp_t e;
        w_valid = wv; w_data = wd; in_valid = iv; in_first = ifst; in_data = idat;
        #1;
        exp_rdy = (m_state == 2) && !wv;
        chk("in_ready", if0.in_ready, exp_rdy);
        chk("w_loaded", if0.w_loaded, m_state == 2);
        if (iv && exp_rdy) begin
            for (int r = 0; r < 6; r++) begin
                mwin[r][0] = mwin[r][1];
                mwin[r][1] = mwin[r][2];
                mwin[r][2] = $signed(idat[r*8 +: 8]);
            end
            m_fill = ifst ? 1 : (m_fill == 3 ? 3 : m_fill + 1);
            if (m_fill == 3) begin
                e.due = cyc + 3;
                e.d0 = expect_col(0, relu_en);
                e.d2 = expect_col(2, relu_en);
                q.push_back(e);
            end
        end
        if (wv) begin
            if (m_state == 1) begin
                mw[m_cnt] = $signed(wd);
                if (m_cnt == 8) begin m_state = 2; m_cnt = 0; end
                else m_cnt++;
            end else begin
                if (m_state == 2) begin
                    m_fill = 0;
                    while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
                end
                mw[0] = $signed(wd);
                m_cnt = 1;
                m_state = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic col(input logic first, input logic [47:0] d);
        cycle(1'b0, 8'h00, 1'b1, first, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, '0);
    endtask

    task automatic load_kbuf();
        for (int i = 0; i < 9; i++) cycle(1'b1, kbuf[i][7:0], 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset(input int n);
        w_valid = 0; in_valid = 0; in_first = 0; rst = 1'b1;
        while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_in_ready", if0.in_ready, 1'b0);
        chk("rst_w_loaded", if0.w_loaded, 1'b0);
        chk("rst_out_valid_s0", if0.out_valid, 1'b0);
        chk("rst_out_valid_s2", if2.out_valid, 1'b0);
        chk("rst_out_data_s0", if0.out_data, 32'h0);
        chk("rst_out_data_s2", if2.out_data, 32'h0);
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset(2);

        // kernel rows 1,2,3 across columns; sliding window 0..3
        for (int i = 0; i < 9; i++) kbuf[i] = (i % 3) + 1;
        load_kbuf();
        for (int v = 0; v < 4; v++) col(v == 0, all_rows(v));
        idle(5);

        // saturation high and low
        for (int i = 0; i < 9; i++) kbuf[i] = 127;
        load_kbuf();
        for (int v = 0; v < 3; v++) col(v == 0, all_rows(127));
        idle(5);
        for (int i = 0; i < 9; i++) kbuf[i] = -128;
        load_kbuf();
        for (int v = 0; v < 3; v++) col(v == 0, all_rows(127));
        idle(5);

        // negative results with and without ReLU
        for (int i = 0; i < 9; i++) kbuf[i] = -1;
        load_kbuf();
        for (int v = 0; v < 3; v++) col(v == 0, all_rows(5));
        idle(5);
        relu_en = 1'b1;
        for (int v = 0; v < 3; v++) col(v == 0, all_rows(5));
        idle(5);
        relu_en = 1'b0;

        // reload during streaming, weight beat colliding with a column
        for (int i = 0; i < 9; i++) kbuf[i] = $urandom_range(0, 255);
        load_kbuf();
        for (int v = 0; v < 5; v++) col(v == 0, rnd48());
        for (int i = 0; i < 9; i++) kbuf[i] = $urandom_range(0, 255);
        for (int i = 0; i < 9; i++) cycle(1'b1, kbuf[i][7:0], 1'b1, 1'b0, rnd48());
        for (int v = 0; v < 4; v++) col(1'b0, rnd48());
        idle(5);

        // restart strip on the third column
        for (int v = 0; v < 6; v++) col(v == 0 || v == 2, rnd48());
        idle(5);

        // random traffic
        relu_en = $urandom_range(0, 1);
        for (int i = 0; i < 200; i++)
            cycle(1'b0, 8'h00, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rnd48());
        idle(5);
        relu_en = 1'b0;

        // reset with a result in flight, then streaming is refused until reload
        for (int v = 0; v < 3; v++) col(v == 0, rnd48());
        do_reset(1);
        for (int i = 0; i < 3; i++) col(1'b1, rnd48());
        load_kbuf();
        for (int v = 0; v < 3; v++) col(v == 0, rnd48());
        idle(6);

        chk("q_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
